// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank tracker: command codes, bank state
// encoding, bank count and the timing counter width helper.
package dram_pkg;

  localparam int NUM_BANKS = 8;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_PREA = 3'd3,
    CMD_RD   = 3'd4,
    CMD_WR   = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTING      = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_e;

  // Width of a down-counter able to hold the largest timing parameter.
  function automatic int cnt_width(input int trcd, input int trp, input int tras);
    int m;
    m = trcd;
    if (trp > m) m = trp;
    if (tras > m) m = tras;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: IDLE/ACTING/ACTIVE/PRECHARGING state, open-row register
// and a single timing down-counter.
//
// The counter is loaded with TRAS-1 on ACT and runs down through ACTING and
// ACTIVE, so one counter serves both tRCD (ACTING ends once the count has
// fallen by TRCD-1) and tRAS (PRE allowed once it reaches zero). On PRE it is
// reloaded with TRP-1 and counts the precharge time.
module dram_bank_fsm
  import dram_pkg::*;
#(
  parameter int ROW_W = 14,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TRAS  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             do_act,
  input  logic             do_pre,
  input  logic [ROW_W-1:0] act_row,
  output logic [ROW_W-1:0] row,
  output logic             act_ok,
  output logic             rw_ok,
  output logic             pre_ok,
  output logic             is_open
);

  localparam int CNT_W = cnt_width(TRCD, TRP, TRAS);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(TRAS - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(TRP - 1);
  // Count value in the last ACTING cycle: TRAS-1 minus (TRCD-2) elapsed cycles.
  localparam logic [CNT_W-1:0] RCD_DONE = CNT_W'(TRAS - TRCD + 1);

  bank_state_e      state;
  logic [CNT_W-1:0] cnt;

  // Bank state machine, timing counter and open-row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BANK_IDLE;
      cnt   <= CNT_ZERO;
      row   <= '0;
    end else begin
      case (state)
        BANK_IDLE: begin
          if (do_act) begin
            row   <= act_row;
            cnt   <= RAS_LOAD;
            state <= (TRCD <= 1) ? BANK_ACTIVE : BANK_ACTING;
          end
        end
        BANK_ACTING: begin
          if (cnt != CNT_ZERO) cnt <= cnt - CNT_ONE;
          if (cnt <= RCD_DONE) state <= BANK_ACTIVE;
        end
        BANK_ACTIVE: begin
          if (do_pre) begin
            cnt   <= RP_LOAD;
            state <= (TRP <= 1) ? BANK_IDLE : BANK_PRECHARGING;
          end else if (cnt != CNT_ZERO) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        BANK_PRECHARGING: begin
          if (cnt <= CNT_ONE) begin
            cnt   <= CNT_ZERO;
            state <= BANK_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          cnt   <= CNT_ZERO;
          state <= BANK_IDLE;
        end
      endcase
    end
  end

  // Legality flags are pure decodes of the registered state and counter.
  always_comb begin
    act_ok  = (state == BANK_IDLE);
    rw_ok   = (state == BANK_ACTIVE);
    pre_ok  = (state == BANK_ACTIVE) && (cnt == CNT_ZERO);
    is_open = (state == BANK_ACTING) || (state == BANK_ACTIVE);
  end

endmodule

// File: rtl/dram_bank_tracker.sv
// Eight-bank DRAM timing/state tracker. Decodes commands, checks legality
// against per-bank timing state and drives the bank FSMs.
// Optional feature: define DRAM_BANK_TRACKER_ERR_EN to get a sticky
// err_illegal flag; otherwise err_illegal is tied low.
// An open bank still in ACTING has pre_ok=0, so it makes PREA illegal.
// Command code 7 is undefined and treated like NOP.
module dram_bank_tracker
  import dram_pkg::*;
#(
  parameter int ROW_W = 14,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TRAS  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [NUM_BANKS-1:0] bank_sel,
  input  logic [ROW_W-1:0]     cmd_row,
  output logic [NUM_BANKS-1:0] act_ok,
  output logic [NUM_BANKS-1:0] rw_ok,
  output logic [NUM_BANKS-1:0] pre_ok,
  output logic [NUM_BANKS-1:0] row_hit,
  output logic                 all_idle,
  output logic                 err_illegal
);

  cmd_e                 cmd_code;
  logic                 sel_onehot;
  logic                 act_legal;
  logic                 pre_legal;
  logic                 prea_legal;
  logic                 act_go;
  logic                 pre_go;
  logic                 prea_go;
  logic [NUM_BANKS-1:0] bank_open;
  logic [NUM_BANKS-1:0] do_act;
  logic [NUM_BANKS-1:0] do_pre;
  logic [ROW_W-1:0]     bank_row [NUM_BANKS];

  assign cmd_code   = cmd_e'(cmd);
  assign sel_onehot = (bank_sel != '0) &&
                      ((bank_sel & (bank_sel - NUM_BANKS'(1))) == '0);
  assign act_legal  = sel_onehot && ((bank_sel & act_ok) != '0);
  assign pre_legal  = sel_onehot && ((bank_sel & pre_ok) != '0);
  assign prea_legal = ((bank_open & ~pre_ok) == '0);

  assign act_go  = cmd_valid && (cmd_code == CMD_ACT)  && act_legal;
  assign pre_go  = cmd_valid && (cmd_code == CMD_PRE)  && pre_legal;
  assign prea_go = cmd_valid && (cmd_code == CMD_PREA) && prea_legal;

  assign all_idle = &act_ok;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign do_act[gi] = act_go & bank_sel[gi];
    assign do_pre[gi] = (pre_go & bank_sel[gi]) | (prea_go & pre_ok[gi]);

    dram_bank_fsm #(
      .ROW_W (ROW_W),
      .TRCD  (TRCD),
      .TRP   (TRP),
      .TRAS  (TRAS)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .do_act  (do_act[gi]),
      .do_pre  (do_pre[gi]),
      .act_row (cmd_row),
      .row     (bank_row[gi]),
      .act_ok  (act_ok[gi]),
      .rw_ok   (rw_ok[gi]),
      .pre_ok  (pre_ok[gi]),
      .is_open (bank_open[gi])
    );

    assign row_hit[gi] = bank_open[gi] && (bank_row[gi] == cmd_row);
  end

`ifdef DRAM_BANK_TRACKER_ERR_EN
  logic rw_legal;
  logic illegal;

  assign rw_legal = sel_onehot && ((bank_sel & rw_ok) != '0);

  // Flag any valid command that the current bank state does not allow.
  always_comb begin
    illegal = 1'b0;
    if (cmd_valid) begin
      case (cmd_code)
        CMD_ACT:        illegal = !act_legal;
        CMD_PRE:        illegal = !pre_legal;
        CMD_PREA:       illegal = !prea_legal;
        CMD_RD, CMD_WR: illegal = !rw_legal;
        CMD_REF:        illegal = !all_idle;
        default:        illegal = 1'b0;
      endcase
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (illegal) begin
      err_illegal <= 1'b1;
    end
  end
`else
  assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_dram_bank_tracker.sv
// Scoreboard bench for dram_bank_tracker: directed scenarios followed by
// random commands, checked against a timestamp-based bank model.
module tb_dram_bank_tracker;
  import dram_pkg::*;

  localparam int ROW_W = 14;
  localparam int TRCD  = 3;
  localparam int TRP   = 3;
  localparam int TRAS  = 6;
  localparam int NB    = 8;

`ifdef DRAM_BANK_TRACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd = 3'd0;
  logic [NB-1:0]    bank_sel = '0;
  logic [ROW_W-1:0] cmd_row = '0;
  logic [NB-1:0]    act_ok, rw_ok, pre_ok, row_hit;
  logic             all_idle, err_illegal;

  dram_bank_tracker #(
    .ROW_W (ROW_W),
    .TRCD  (TRCD),
    .TRP   (TRP),
    .TRAS  (TRAS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .bank_sel    (bank_sel),
    .cmd_row     (cmd_row),
    .act_ok      (act_ok),
    .rw_ok       (rw_ok),
    .pre_ok      (pre_ok),
    .row_hit     (row_hit),
    .all_idle    (all_idle),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] act_ok;
    logic [NB-1:0] rw_ok;
    logic [NB-1:0] pre_ok;
    logic [NB-1:0] row_hit;
    logic          all_idle;
    logic          err;
  } snap_t;

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  longint cyc = 0;

  // Reference model: each bank remembers when it was last activated or
  // precharged; legality is elapsed time compared with the timing params.
  bit               m_open  [NB];
  longint           m_act_t [NB];
  longint           m_pre_t [NB];
  logic [ROW_W-1:0] m_row   [NB];
  bit               m_err;

  function automatic bit m_rw(input int b);
    return m_open[b] && (cyc >= m_act_t[b] + TRCD);
  endfunction

  function automatic bit m_pre(input int b);
    return m_open[b] && (cyc >= m_act_t[b] + TRAS);
  endfunction

  function automatic bit m_act(input int b);
    return !m_open[b] && (cyc >= m_pre_t[b] + TRP);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b]  = 1'b0;
      m_act_t[b] = -1000;
      m_pre_t[b] = -1000;
      m_row[b]   = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // Issue one command for one cycle; record the outputs expected during it.
  task automatic step(input bit v, input logic [2:0] c, input logic [NB-1:0] sel,
                      input logic [ROW_W-1:0] r);
    snap_t e;
    bit    legal;
    bit    onehot;
    int    bi;
    cmd_valid = v;
    cmd       = c;
    bank_sel  = sel;
    cmd_row   = r;
    for (int b = 0; b < NB; b++) begin
      e.act_ok[b]  = m_act(b);
      e.rw_ok[b]   = m_rw(b);
      e.pre_ok[b]  = m_pre(b);
      e.row_hit[b] = m_open[b] && (m_row[b] == r);
    end
    e.all_idle = (e.act_ok == {NB{1'b1}});
    e.err      = ERR_EN ? m_err : 1'b0;
    exp_q.push_back(e);
    $display("[TB] cyc %0d valid %0d cmd %0d sel %h row %h", cyc, v, c, sel, r);

    onehot = ($countones(sel) == 1);
    bi = 0;
    for (int b = 0; b < NB; b++) if (sel[b]) bi = b;
    legal = 1'b1;
    if (v) begin
      case (c)
        3'd1: begin
          legal = onehot && m_act(bi);
          if (legal) begin
            m_open[bi] = 1'b1; m_act_t[bi] = cyc; m_row[bi] = r;
          end
        end
        3'd2: begin
          legal = onehot && m_pre(bi);
          if (legal) begin
            m_open[bi] = 1'b0; m_pre_t[bi] = cyc;
          end
        end
        3'd3: begin
          for (int b = 0; b < NB; b++) if (m_open[b] && !m_pre(b)) legal = 1'b0;
          if (legal) begin
            for (int b = 0; b < NB; b++) begin
              if (m_open[b]) begin
                m_open[b] = 1'b0; m_pre_t[b] = cyc;
              end
            end
          end
        end
        3'd4, 3'd5: legal = onehot && m_rw(bi);
        3'd6: begin
          for (int b = 0; b < NB; b++) if (!m_act(b)) legal = 1'b0;
        end
        default: legal = 1'b1;
      endcase
    end
    if (!legal) m_err = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pull reset mid-cycle and check the asynchronous effect at once.
  task automatic reset_pulse();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_act_ok", act_ok, {NB{1'b1}});
    chk("rst_rw_ok", rw_ok, '0);
    chk("rst_pre_ok", pre_ok, '0);
    chk("rst_err", {7'd0, err_illegal}, '0);
    chk("rst_all_idle", {7'd0, all_idle}, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc += 2;
    model_reset();
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    snap_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("act_ok", act_ok, e.act_ok);
      chk("rw_ok", rw_ok, e.rw_ok);
      chk("pre_ok", pre_ok, e.pre_ok);
      chk("row_hit", row_hit, e.row_hit);
      chk("all_idle", {7'd0, all_idle}, {7'd0, e.all_idle});
      chk("err_illegal", {7'd0, err_illegal}, {7'd0, e.err});
    end
  end

  initial begin
    logic [ROW_W-1:0] rr;
    logic [NB-1:0]    ss;
    logic [2:0]       cc;
    int               pick;
    bit               vv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and idle behaviour.
    repeat (3) step(1'b0, 3'd0, 8'h00, 14'h0000);

    // ACT bank 2, tRCD/tRAS timing, row hit/miss, early PRE, legal PRE.
    step(1'b1, CMD_ACT, 8'h04, 14'h0123);
    repeat (3) step(1'b1, CMD_NOP, 8'h00, 14'h0123);
    step(1'b1, CMD_PRE, 8'h04, 14'h0123);
    step(1'b0, CMD_NOP, 8'h00, 14'h0124);
    step(1'b1, CMD_PRE, 8'h04, 14'h0123);
    repeat (3) step(1'b0, CMD_NOP, 8'h00, 14'h0123);

    // Bad bank selects, then REF with bank 0 open.
    step(1'b1, CMD_ACT, 8'h06, 14'h0010);
    step(1'b1, CMD_ACT, 8'h00, 14'h0010);
    step(1'b1, CMD_ACT, 8'h01, 14'h0011);
    repeat (3) step(1'b0, CMD_NOP, 8'h00, 14'h0011);
    step(1'b1, CMD_REF, 8'h00, 14'h0011);
    step(1'b1, CMD_RD, 8'h01, 14'h0011);

    // Bank 5 open too, PREA once both have met tRAS.
    step(1'b1, CMD_ACT, 8'h20, 14'h0055);
    step(1'b1, CMD_PREA, 8'h00, 14'h0055);
    repeat (6) step(1'b0, CMD_NOP, 8'h00, 14'h0055);
    step(1'b1, CMD_PREA, 8'h00, 14'h0055);
    repeat (4) step(1'b0, CMD_NOP, 8'h00, 14'h0055);
    step(1'b1, CMD_REF, 8'h00, 14'h0000);

    // Reset while bank 7 is still ACTING.
    step(1'b1, CMD_ACT, 8'h80, 14'h0777);
    step(1'b0, CMD_NOP, 8'h00, 14'h0777);
    reset_pulse();
    repeat (2) step(1'b0, CMD_NOP, 8'h00, 14'h0777);

    // Random traffic with small row set for frequent hits.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_pulse();
      vv   = ($urandom_range(0, 9) != 0);
      pick = $urandom_range(0, 15);
      if (pick <= 4)       cc = 3'd1;
      else if (pick <= 8)  cc = 3'd2;
      else if (pick == 9)  cc = 3'd3;
      else if (pick <= 11) cc = 3'd4;
      else if (pick == 12) cc = 3'd5;
      else if (pick == 13) cc = 3'd6;
      else                 cc = 3'd0;
      if ($urandom_range(0, 7) == 0) ss = NB'($urandom_range(0, 255));
      else                           ss = NB'(1) << $urandom_range(0, NB - 1);
      rr = ROW_W'($urandom_range(0, 3));
      step(vv, cc, ss, rr);
    end

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_bank_tracker.md
DRAM_BANK_TRACKER -- requirements
Module: dram_bank_tracker

Interface
REQ-001 SHALL have parameter ROW_W, default 14, row address width.
REQ-002 SHALL have parameter TRCD, default 3, ACT-to-RD/WR cycles (>=1).
REQ-003 SHALL have parameter TRP, default 3, PRE-to-ACT cycles (>=1).
REQ-004 SHALL have parameter TRAS, default 6, ACT-to-PRE minimum cycles (>=TRCD).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1, command strobe.
REQ-008 SHALL have port cmd, input, 3, command code (NOP, ACT, PRE, PREA, RD, WR, REF).
REQ-009 SHALL have port bank_sel, input, 8, one-hot bank select from the 3-to-8 bank decoder.
REQ-010 SHALL have port cmd_row, input, ROW_W, row for ACT and for row-hit compare.
REQ-011 SHALL have ports act_ok, rw_ok, pre_ok, output, 8 each, per-bank legality of ACT, RD/WR, PRE.
REQ-012 SHALL have port row_hit, output, 8, bank open AND stored row == cmd_row.
REQ-013 SHALL have port all_idle, output, 1, every bank IDLE with TRP elapsed.
REQ-014 SHALL have port err_illegal, output, 1, sticky illegal-command flag.

Function
REQ-015 SHALL keep per bank a 4-state FSM: IDLE, ACTING, ACTIVE, PRECHARGING, a stored row, and a down-counter sized clog2(max(TRCD,TRP,TRAS)+1).
REQ-016 SHALL accept a command only when cmd_valid=1; cmd_valid=0 or NOP changes no state.
REQ-017 SHALL, on legal ACT at cycle N to bank b: store cmd_row, enter ACTING; rw_ok[b]=1 from cycle N+TRCD (ACTIVE); pre_ok[b]=1 from cycle N+TRAS.
REQ-018 SHALL, on legal PRE at cycle N to bank b: enter PRECHARGING; act_ok[b]=1 from cycle N+TRP (IDLE).
REQ-019 SHALL treat PREA as PRE to every ACTIVE bank; legal only if pre_ok=1 for all ACTIVE banks; IDLE/PRECHARGING banks unaffected.
REQ-020 SHALL treat RD/WR as legal only when rw_ok[b]=1; no state change.
REQ-021 SHALL treat REF as legal only when all_idle=1; no state change.
REQ-022 SHALL treat ACT/PRE/RD/WR with bank_sel zero or not one-hot as illegal.
REQ-023 SHALL ignore illegal commands entirely (no state, row or counter change).
REQ-024 SHALL derive act_ok, rw_ok, pre_ok, all_idle only from registered state (no input-to-output path); row_hit is combinational from cmd_row.
REQ-025 SHALL keep stored row unchanged through PRECHARGING; row_hit=0 outside ACTING/ACTIVE.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force all banks IDLE, counters 0, rows 0, err_illegal 0.
REQ-027 SHALL after reset show act_ok=8'hFF, rw_ok=0, pre_ok=0, row_hit=0, all_idle=1; reset mid-ACTING/PRECHARGING aborts timing with no residual delay.

Configuration
REQ-028 SHALL with DRAM_BANK_TRACKER_ERR_EN defined set err_illegal the cycle after any illegal command, held until reset.
REQ-029 SHALL without DRAM_BANK_TRACKER_ERR_EN tie err_illegal to 0; illegal commands still ignored.

Structure
REQ-030 SHALL take command encodings, bank-state enum and NUM_BANKS=8 from shared package dram_pkg.
REQ-031 SHALL implement per-bank FSM, counter and row register in sub-module dram_bank_fsm, instantiated 8 times.

Verification (TRCD=3, TRP=3, TRAS=6, ERR_EN defined)
REQ-032 SHALL cover ACT bank 2 row 0x123 at cycle 10 -> rw_ok[2]=1 at cycle 13, pre_ok[2]=1 at cycle 16, row_hit[2]=1 for cmd_row=0x123, 0 for 0x124.
REQ-033 SHALL cover PRE bank 2 at cycle 16 -> act_ok[2]=0 cycles 17-18, =1 at cycle 19, all_idle=1 at cycle 19.
REQ-034 SHALL cover PRE bank 2 at cycle 14 (tRAS unmet) -> ignored, bank stays ACTIVE, err_illegal=1 at cycle 15.
REQ-035 SHALL cover bank_sel=8'b00000110 with ACT -> no bank changes, err_illegal=1; REF while bank 0 ACTIVE -> ignored.
REQ-036 SHALL cover ACT banks 0,5 then PREA after TRAS -> both PRECHARGING, act_ok=8'hFF three cycles later.
REQ-037 SHALL cover rst_n low mid-ACTING on bank 7 -> act_ok[7]=1, rw_ok[7]=0, err_illegal=0 immediately.
